// File: rtl/fft_seq_ctrl.sv
// Address sequencer for an in-place 128-point radix-2 DIF FFT.
// Issues one butterfly operand pair per cycle with its twiddle address,
// inserts BF_LAT-cycle drain gaps between stages, and delays the operand
// addresses by BF_LAT cycles to form the write-back strobe/addresses.
module fft_seq_ctrl #(
    parameter int LOG2N  = 7,
    parameter int BF_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [2:0] stage,
    output logic       rd_en,
    output logic [6:0] rd_addr_a,
    output logic [6:0] rd_addr_b,
    output logic [5:0] tw_addr,
    output logic       wr_en,
    output logic [6:0] wr_addr_a,
    output logic [6:0] wr_addr_b
);

    localparam int NBF = (1 << LOG2N) / 2;  // butterflies per stage

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       en;
        logic [6:0] a;
        logic [6:0] b;
    } wb_t;

    state_t            state, state_nxt;
    logic [5:0]        j;
    logic [2:0]        stg;
    logic [2:0]        dcnt;
    logic              last_bf, last_drain, last_stage;
    logic [2:0]        pos;
    logic [6:0]        j_ext, bit_sel, lo_mask, addr_a, addr_b;
    logic [5:0]        tw_nxt;
    wb_t [BF_LAT-1:0]  wb_pipe;

    assign last_bf    = (j == 6'(NBF - 1));
    assign last_drain = (dcnt == 3'(BF_LAT - 1));
    assign last_stage = (stg == 3'(LOG2N - 1));

    // Operand addresses: j with a zero (A) or one (B) inserted at bit 6-stage.
    always_comb begin
        pos     = 3'd6 - stg;
        j_ext   = {1'b0, j};
        bit_sel = 7'd1 << pos;
        lo_mask = bit_sel - 7'd1;
        addr_a  = ((j_ext & ~lo_mask) << 1) | (j_ext & lo_mask);
        addr_b  = addr_a | bit_sel;
        tw_nxt  = j << stg;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bf) state_nxt = DRAIN;
            DRAIN:   if (last_drain) state_nxt = last_stage ? DONE : RUN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Butterfly, stage and drain counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j    <= '0;
            stg  <= '0;
            dcnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    j    <= '0;
                    dcnt <= '0;
                    if (start) stg <= '0;
                end
                RUN: begin
                    j    <= j + 6'd1;   // wraps to 0 after the last butterfly
                    dcnt <= '0;
                end
                DRAIN: begin
                    dcnt <= dcnt + 3'd1;
                    if (last_drain && !last_stage) stg <= stg + 3'd1;
                end
                default: dcnt <= '0;
            endcase
        end
    end

    // Registered read-side outputs; addresses and stage hold outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            stage     <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            busy  <= (state != IDLE);
            done  <= (state == DONE);
            rd_en <= (state == RUN);
            if (state == RUN) begin
                stage     <= stg;
                rd_addr_a <= addr_a;
                rd_addr_b <= addr_b;
                tw_addr   <= tw_nxt;
            end
        end
    end

    // Write-back delay line, free running so in-flight writes finish during drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_pipe <= '0;
        end else begin
            wb_pipe[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < BF_LAT; i++) wb_pipe[i] <= wb_pipe[i-1];
        end
    end

    assign wr_en     = wb_pipe[BF_LAT-1].en;
    assign wr_addr_a = wb_pipe[BF_LAT-1].a;
    assign wr_addr_b = wb_pipe[BF_LAT-1].b;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: a cycle-indexed schedule model derived
// from the stage/butterfly arithmetic plus a read/write scoreboard.
module tb_fft_seq_ctrl;

    localparam int BF_LAT   = 3;
    localparam int PER      = 64 + BF_LAT;
    localparam int DONE_CYC = 1 + 7 * PER;
    localparam int RUN_LEN  = DONE_CYC + 2;

    typedef struct {
        int c;
        int a;
        int b;
        int s;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, rd_en, wr_en;
    logic [2:0] stage;
    logic [6:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [5:0] tw_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_seq_ctrl #(.LOG2N(7), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .stage(stage),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_addr(tw_addr), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    // Read issued in cycle c (relative to start accepted at edge 0)?
    function automatic bit rd_at(input int c, output int a, output int b,
                                 output int tw, output int s);
        int k, j, span;
        a = 0; b = 0; tw = 0; s = 0;
        k = c - 1;
        if (k < 0 || k >= 7 * PER) return 1'b0;
        s = k / PER;
        j = k % PER;
        if (j >= 64) return 1'b0;
        span = 64 >> s;
        a  = (j / span) * 2 * span + (j % span);
        b  = a + span;
        tw = (j * (1 << s)) % 64;
        return 1'b1;
    endfunction

    // One transform starting at the next edge; smask marks extra start pulses.
    task automatic test_transform(input bit [511:0] smask, input int n_cycles,
                                  input bit vec, input bit full, input string tag);
        int   cov [8][128];
        int   first_rd [8];
        int   last_wr [8];
        rec_t q[$];
        rec_t r;
        int   rd_cnt, wr_cnt, done_cnt;
        int   ea, eb, etw, es, ha, hb, htw, hs, wa, wb, wtw, ws;
        bit   erd, ewr, hold, ok;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        for (int s = 0; s < 8; s++) begin
            first_rd[s] = -1;
            last_wr[s]  = -1;
            for (int i = 0; i < 128; i++) cov[s][i] = 0;
        end
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clk);
            erd  = rd_at(c, ea, eb, etw, es);
            ewr  = rd_at(c - BF_LAT, wa, wb, wtw, ws);
            hold = erd;
            ha = ea; hb = eb; htw = etw; hs = es;
            for (int d = 1; d <= BF_LAT && !hold; d++)
                hold = rd_at(c - d, ha, hb, htw, hs);
            checks++;
            if (busy !== (c >= 1 && c <= DONE_CYC)) begin
                errors++; $display("FAIL %s busy c=%0d got %b", tag, c, busy);
            end
            checks++;
            if (done !== (c == DONE_CYC)) begin
                errors++; $display("FAIL %s done c=%0d got %b", tag, c, done);
            end
            checks++;
            if (rd_en !== erd) begin
                errors++; $display("FAIL %s rd_en c=%0d got %b want %b", tag, c, rd_en, erd);
            end
            checks++;
            if (wr_en !== ewr) begin
                errors++; $display("FAIL %s wr_en c=%0d got %b want %b", tag, c, wr_en, ewr);
            end
            if (hold && c <= DONE_CYC) begin
                checks++;
                if (rd_addr_a !== 7'(ha) || rd_addr_b !== 7'(hb) || tw_addr !== 6'(htw)) begin
                    errors++;
                    $display("FAIL %s rd_addr c=%0d got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                             tag, c, rd_addr_a, rd_addr_b, tw_addr, ha, hb, htw);
                end
            end
            if (erd) begin
                checks++;
                if (stage !== 3'(es)) begin
                    errors++; $display("FAIL %s stage c=%0d got %0d want %0d", tag, c, stage, es);
                end
            end
            if (ewr) begin
                checks++;
                if (wr_addr_a !== 7'(wa) || wr_addr_b !== 7'(wb)) begin
                    errors++;
                    $display("FAIL %s wr_addr c=%0d got a=%0d b=%0d want a=%0d b=%0d",
                             tag, c, wr_addr_a, wr_addr_b, wa, wb);
                end
            end
            if (vec && (c == 6 || c == 215 || c == 466)) begin
                if (c == 6)        begin ea = 5;   eb = 69;  etw = 5;  end
                else if (c == 215) begin ea = 21;  eb = 29;  etw = 40; end
                else               begin ea = 126; eb = 127; etw = 0;  end
                checks++;
                if (rd_en !== 1'b1 || rd_addr_a !== 7'(ea) || rd_addr_b !== 7'(eb) || tw_addr !== 6'(etw)) begin
                    errors++;
                    $display("FAIL %s vector c=%0d got en=%b a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                             tag, c, rd_en, rd_addr_a, rd_addr_b, tw_addr, ea, eb, etw);
                end
            end
            // scoreboard on observed traffic
            if (done === 1'b1) done_cnt++;
            if (rd_en === 1'b1) begin
                rd_cnt++;
                cov[stage][rd_addr_a]++;
                cov[stage][rd_addr_b]++;
                if (first_rd[stage] < 0) first_rd[stage] = c;
                q.push_back('{c: c, a: int'(rd_addr_a), b: int'(rd_addr_b), s: int'(stage)});
            end
            if (wr_en === 1'b1) begin
                wr_cnt++;
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL %s wr_orphan c=%0d got wr_en with no read", tag, c);
                end else begin
                    r = q.pop_front();
                    last_wr[r.s] = c;
                    if (wr_addr_a !== 7'(r.a) || wr_addr_b !== 7'(r.b) || c - r.c != BF_LAT) begin
                        errors++;
                        $display("FAIL %s wr_match c=%0d got a=%0d b=%0d lag=%0d want a=%0d b=%0d lag=%0d",
                                 tag, c, wr_addr_a, wr_addr_b, c - r.c, r.a, r.b, BF_LAT);
                    end
                end
            end
            start = (c + 1 < 512) ? smask[c+1] : 1'b0;
        end
        start = 1'b0;
        if (full) begin
            checks++;
            if (rd_cnt != 448 || wr_cnt != 448) begin
                errors++; $display("FAIL %s counts got rd=%0d wr=%0d want 448/448", tag, rd_cnt, wr_cnt);
            end
            checks++;
            if (done_cnt != 1) begin
                errors++; $display("FAIL %s done_count got %0d want 1", tag, done_cnt);
            end
            for (int s = 0; s < 7; s++) begin
                ok = 1'b1;
                for (int i = 0; i < 128; i++) if (cov[s][i] != 1) ok = 1'b0;
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL %s coverage stage=%0d got pairs not a partition of 0..127", tag, s);
                end
            end
            for (int s = 0; s < 6; s++) begin
                checks++;
                if (!(first_rd[s+1] > last_wr[s]) || last_wr[s] < 0) begin
                    errors++;
                    $display("FAIL %s hazard stage=%0d got first_rd=%0d last_wr=%0d want first_rd>last_wr",
                             tag, s, first_rd[s+1], last_wr[s]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b} !== '0) begin
            errors++; $display("FAIL reset_outputs got busy=%b done=%b rd_en=%b wr_en=%b want all 0",
                               busy, done, rd_en, wr_en);
        end
        rst = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            checks++;
            if ({wr_en, rd_en, busy, done} !== 4'b0) begin
                errors++; $display("FAIL idle c=%0d got wr=%b rd=%b busy=%b done=%b want 0",
                                   c, wr_en, rd_en, busy, done);
            end
        end
    endtask

    task automatic test_full();
        test_transform('0, RUN_LEN, 1'b1, 1'b1, "full");
    endtask

    task automatic test_start_busy();
        bit [511:0] m;
        m = '0;
        m[100] = 1'b1;
        m[300] = 1'b1;
        m[470] = 1'b1;
        m[$urandom_range(1, 470)] = 1'b1;
        m[$urandom_range(1, 470)] = 1'b1;
        test_transform(m, RUN_LEN, 1'b0, 1'b1, "busy_start");
        // back-to-back: this start lands on absolute edge 472
        test_transform('0, RUN_LEN, 1'b0, 1'b1, "back_to_back");
    endtask

    task automatic test_reset_mid();
        test_transform('0, 200, 1'b0, 1'b0, "pre_reset");
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b} !== '0) begin
            errors++; $display("FAIL async_reset got busy=%b rd_en=%b wr_en=%b stage=%0d want all 0",
                               busy, rd_en, wr_en, stage);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if ({wr_en, rd_en, busy} !== 3'b0) begin
                errors++; $display("FAIL post_reset c=%0d got wr=%b rd=%b busy=%b want 0",
                                   c, wr_en, rd_en, busy);
            end
        end
        test_transform('0, RUN_LEN, 1'b0, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        bit [511:0] m;
        int gap;
        for (int n = 0; n < 3; n++) begin
            gap = $urandom_range(0, 15);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if ({busy, wr_en, rd_en} !== 3'b0) begin
                    errors++; $display("FAIL gap n=%0d got busy=%b wr=%b rd=%b want 0", n, busy, wr_en, rd_en);
                end
            end
            m = '0;
            for (int p = 0; p < 4; p++) m[$urandom_range(1, 470)] = 1'b1;
            test_transform(m, RUN_LEN, 1'b0, 1'b1, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_full();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Sequencer for the in-place 128-point radix-2 decimation-in-frequency (DIF) FFT engine.
- Each butterfly cycle it drives the A/B read addresses of the sample RAM and the 6-bit address of the 64-entry twiddle ROM. The ROM holds W^k = exp(-j2πk/128), Q1.11 in 13 bits.
- It delays the addresses through a write-back pipeline that matches the butterfly latency.
- It inserts drain gaps between stages so no read sees stale data, and reports busy/done to the audio frame logic.

Parameters:
- LOG2N, 7, log2 of the transform length; fixed for the 6-bit twiddle ROM; only 7 is supported.
- BF_LAT, 3, cycles from rd_en to the matching wr_en (RAM read + butterfly pipeline); legal range 1..8.

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request a transform; sampled only in IDLE.
- busy, output, 1, high from the cycle after start is accepted through the done cycle.
- done, output, 1, one-cycle pulse after the last write-back.
- stage, output, 3, current stage 0..6, for per-stage scaling in the datapath.
- rd_en, output, 1, read strobe for the butterfly operand pair.
- rd_addr_a, output, 7, address of the top operand.
- rd_addr_b, output, 7, address of the bottom operand.
- tw_addr, output, 6, twiddle ROM address, aligned with rd_addr_*.
- wr_en, output, 1, write strobe; equals rd_en delayed BF_LAT cycles.
- wr_addr_a, output, 7, rd_addr_a delayed BF_LAT cycles.
- wr_addr_b, output, 7, rd_addr_b delayed BF_LAT cycles.

Behaviour:
- Reset (async, any state): FSM goes to IDLE. Every output is 0: busy, done, stage, rd_en, rd_addr_*, tw_addr, wr_en, wr_addr_*. Counters and the delay line are cleared, so no wr_en appears after reset, including mid-transform.
- All outputs are registered.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 moves to RUN with stage=0, j=0. start in any other state is ignored; no queuing.
- RUN: one butterfly per cycle, rd_en=1, 6-bit butterfly counter j=0..63.
  - span = 64>>stage.
  - rd_addr_a = j with a 0 inserted at bit position (6-stage); equivalently group*2*span + (j mod span).
  - rd_addr_b = rd_addr_a + span, i.e. the same bit set to 1.
  - tw_addr = (j << stage) mod 64.
  - At j=63 the FSM moves to DRAIN.
- DRAIN: rd_en=0 for exactly BF_LAT cycles; rd_addr_* and tw_addr hold their last values.
  - If stage<6: stage increments, j=0, back to RUN.
  - If stage=6: go to DONE.
  - Guarantee: the last write of stage s occurs in the final DRAIN cycle, before the first read of stage s+1. This assumes a synchronous-write RAM.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0. A start in the DONE cycle is ignored.
- Write-back delay line: BF_LAT-deep shift register of {rd_en, rd_addr_a, rd_addr_b}. It runs in every state and is cleared only by rst.
- Timing for BF_LAT=3, with start accepted at edge 0:
  - Stage s reads occur in cycles 1+67s .. 64+67s.
  - First wr_en is in cycle 4; last wr_en is in cycle 469.
  - done is in cycle 470.
  - Total per stage = 64 + BF_LAT cycles; in general done is at cycle 1 + 7*(64+BF_LAT).
- Output order: natural-order input produces bit-reversed output; unscrambling is the readout logic's job, not this block's.

Test Plan:
- Reset then idle: hold rst 5 cycles, start=0 → every output 0; no wr_en for 1000 cycles.
- Full transform, BF_LAT=3, start pulse at edge 0:
  - Stage 0, j=5: rd_addr_a=5, rd_addr_b=69, tw_addr=5.
  - Stage 3, j=13 (span 8): rd_addr_a=21, rd_addr_b=29, tw_addr=40.
  - Stage 6, j=63: rd_addr_a=126, rd_addr_b=127, tw_addr=0.
  - done only in cycle 470; exactly 448 rd_en and 448 wr_en cycles.
- Coverage per stage: a scoreboard checks that the 64 (a,b) pairs cover 0..127 exactly once, and that every wr_addr equals the rd_addr issued BF_LAT cycles earlier.
- Hazard check: for each stage boundary, the first rd_en of stage s+1 occurs strictly after the last wr_en of stage s.
- Start while busy: pulses at cycles 100, 300 and 470 → ignored; done once at 470. A start at 472 begins a second transform whose first rd_en is at 473.
- Reset mid-operation: assert rst at cycle 200 → all outputs 0 immediately (asynchronous); no wr_en afterwards. After release, start runs a clean full transform (done 470 cycles after start).
